// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types, limits and digit weights for the stopwatch display path.
package stopwatch_pkg;
  typedef logic [3:0] bcd_t;
  typedef enum logic {MODE_MMSS, MODE_HHMM} mode_e;
  typedef enum logic [1:0] {IDLE, CONV, DONE} conv_state_e;
  localparam int LIMIT_MMSS = 5999;
  localparam int LIMIT_HHMM = 359999;
  localparam bcd_t BCD_BLANK = 4'hF;
  // Weight of digit k in seconds; HHMM stops at minutes and drops the seconds remainder.
  function automatic logic [16:0] phase_weight(mode_e mode, logic [1:0] k);
    return (mode == MODE_HHMM) ?
      ((k == 2'd0) ? 17'd36000 : (k == 2'd1) ? 17'd3600 : (k == 2'd2) ? 17'd600 : 17'd60) :
      ((k == 2'd0) ? 17'd600 : (k == 2'd1) ? 17'd60 : (k == 2'd2) ? 17'd10 : 17'd1);
  endfunction
endpackage

// File: rtl/time_bcd_converter.sv
// time_bcd_converter: seconds to MM:SS / HH:MM BCD digits by iterative subtraction.
module time_bcd_converter
  import stopwatch_pkg::*;
#(
  parameter int TIME_W   = 17,
  parameter bit LZ_BLANK = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [TIME_W-1:0] seconds_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic              ovf_o,
  output bcd_t              digit1_o,
  output bcd_t              digit2_o,
  output bcd_t              digit3_o,
  output bcd_t              digit4_o
);
  localparam int RW = (TIME_W > 17) ? TIME_W : 17;
  localparam int LIM_H_I = (((1 << TIME_W) - 1) < LIMIT_HHMM) ? ((1 << TIME_W) - 1) : LIMIT_HHMM;
  localparam logic [RW-1:0] LIM_M = RW'(LIMIT_MMSS);
  localparam logic [RW-1:0] LIM_H = RW'(LIM_H_I);

  if (TIME_W < 13 || TIME_W > 24) begin : g_time_w_check
    $error("time_bcd_converter: TIME_W must be within 13..24");
  end

  conv_state_e     state_q, state_d;
  mode_e           mode_q, mode_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [1:0]      phase_q, phase_d;
  bcd_t [0:3]      cnt_q, cnt_d;
  bcd_t [0:3]      dig_q, dig_d;
  logic            flag_q, flag_d;
  logic            ovf_q, ovf_d;
  logic [RW-1:0]   w, sec, lim;
  logic            last;

  assign w    = RW'(phase_weight(mode_q, phase_q));
  assign sec  = RW'(seconds_i);
  assign lim  = mode_i ? LIM_H : LIM_M;
  assign last = (rem_q < w) && (phase_q == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_MMSS;
      rem_q   <= '0;
      phase_q <= '0;
      cnt_q   <= '0;
      dig_q   <= '0;
      flag_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      dig_q   <= dig_d;
      flag_q  <= flag_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = (state_q == IDLE) ? (start_i ? CONV : IDLE) :
              (state_q == CONV) ? (last ? DONE : CONV) : IDLE;
  end

  always_comb begin
    mode_d  = mode_q;
    rem_d   = rem_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    dig_d   = dig_q;
    flag_d  = flag_q;
    ovf_d   = ovf_q;
    if (state_q == IDLE && start_i) begin
      mode_d  = mode_e'(mode_i);
      flag_d  = sec > lim;
      rem_d   = (sec > lim) ? lim : sec;
      phase_d = 2'd0;
      cnt_d   = '0;
    end else if (state_q == CONV) begin
      if (rem_q >= w) begin
        rem_d          = rem_q - w;
        cnt_d[phase_q] = cnt_q[phase_q] + 4'd1;
      end else if (phase_q != 2'd3) begin
        phase_d = phase_q + 2'd1;
      end else begin
        // Results are published only on the edge into DONE, so outputs hold between conversions.
        dig_d    = cnt_q;
        dig_d[0] = (LZ_BLANK && cnt_q[0] == 4'd0) ? BCD_BLANK : cnt_q[0];
        ovf_d    = flag_q;
      end
    end
  end

  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign ovf_o    = ovf_q;
  assign digit1_o = dig_q[0];
  assign digit2_o = dig_q[1];
  assign digit3_o = dig_q[2];
  assign digit4_o = dig_q[3];
endmodule

// File: tb/tb_time_bcd_converter.sv
// tb_time_bcd_converter: randomized and directed checks of two converter configurations against a div/mod model.
module tb_time_bcd_converter;
  import stopwatch_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0, mode = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [16:0] sec1 = '0;
  logic [18:0] sec2 = '0;
  logic rdy1, vld1, ovf1, rdy2, vld2, ovf2;
  bcd_t a1, a2, a3, a4, b1, b2, b3, b4;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  time_bcd_converter #(.TIME_W(17), .LZ_BLANK(1'b0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start_i(start1), .mode_i(mode), .seconds_i(sec1),
    .ready_o(rdy1), .valid_o(vld1), .ovf_o(ovf1),
    .digit1_o(a1), .digit2_o(a2), .digit3_o(a3), .digit4_o(a4));

  time_bcd_converter #(.TIME_W(19), .LZ_BLANK(1'b1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .start_i(start2), .mode_i(mode), .seconds_i(sec2),
    .ready_o(rdy2), .valid_o(vld2), .ovf_o(ovf2),
    .digit1_o(b1), .digit2_o(b2), .digit3_o(b3), .digit4_o(b4));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input int tw, input bit lz, input bit m, input int s,
                                output logic [15:0] dig, output bit ov, output int lat);
    int lim, v, hi, lo;
    int d[4];
    lim = m ? ((((1 << tw) - 1) < 359999) ? ((1 << tw) - 1) : 359999) : 5999;
    ov  = s > lim;
    v   = ov ? lim : s;
    hi  = m ? v / 3600 : v / 60;
    lo  = m ? (v % 3600) / 60 : v % 60;
    d[0] = hi / 10; d[1] = hi % 10; d[2] = lo / 10; d[3] = lo % 10;
    lat = 5 + d[0] + d[1] + d[2] + d[3];
    dig = {(lz && d[0] == 0) ? 4'hF : 4'(d[0]), 4'(d[1]), 4'(d[2]), 4'(d[3])};
  endfunction

  function automatic logic [15:0] digs(input bit sel);
    return sel ? {b1, b2, b3, b4} : {a1, a2, a3, a4};
  endfunction

  task automatic req(input bit sel, input bit m, input int s, input bit hammer);
    logic [15:0] ed;
    bit eo, got;
    int lat, cyc;
    model(sel ? 19 : 17, sel, m, s, ed, eo, lat);
    @(negedge clk);
    check("ready_idle", {31'd0, sel ? rdy2 : rdy1}, 1);
    mode = m;
    if (sel) begin sec2 = 19'(s); start2 = 1'b1; end
    else begin sec1 = 17'(s); start1 = 1'b1; end
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 64) begin
      @(negedge clk);
      cyc++;
      got = sel ? vld2 : vld1;
      if (sel ? rdy2 : rdy1) got = 1'b0;
      mode = ~m;
      sec1 = 17'($urandom);
      sec2 = 19'($urandom);
      if (!hammer) begin start1 = 1'b0; start2 = 1'b0; end
    end
    start1 = 1'b0;
    start2 = 1'b0;
    check("valid_seen", {31'd0, got}, 1);
    check("latency", cyc, lat);
    check("digits", {16'd0, digs(sel)}, {16'd0, ed});
    check("ovf", {31'd0, sel ? ovf2 : ovf1}, {31'd0, eo});
    @(negedge clk);
    check("valid_pulse", {31'd0, sel ? vld2 : vld1}, 0);
    check("hold", {16'd0, digs(sel)}, {16'd0, ed});
  endtask

  task automatic reset_state(input string tag);
    check({tag, "_ctl1"}, {29'd0, rdy1, vld1, ovf1}, 32'b100);
    check({tag, "_dig1"}, {16'd0, digs(1'b0)}, 0);
    check({tag, "_ctl2"}, {29'd0, rdy2, vld2, ovf2}, 32'b100);
    check({tag, "_dig2"}, {16'd0, digs(1'b1)}, 0);
  endtask

  task automatic reset_mid;
    bit seen;
    @(negedge clk);
    mode = 1'b0; sec1 = 17'd5999; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    seen = vld1;
    repeat (8) begin @(negedge clk); seen |= vld1; end
    reset_n = 1'b0;
    #1;
    reset_state("reset_mid");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (40) begin @(negedge clk); seen |= vld1; end
    check("no_valid_after_abort", {31'd0, seen}, 0);
    req(1'b0, 1'b0, 125, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset_state("reset");
    reset_n = 1'b1;
    req(1'b0, 1'b0, 125, 1'b0);
    req(1'b0, 1'b0, 5999, 1'b0);
    req(1'b0, 1'b0, 6000, 1'b0);
    req(1'b0, 1'b0, 0, 1'b0);
    req(1'b0, 1'b1, 3725, 1'b0);
    req(1'b0, 1'b1, 131071, 1'b0);
    req(1'b0, 1'b1, 0, 1'b0);
    req(1'b1, 1'b1, 360000, 1'b0);
    req(1'b1, 1'b1, 359999, 1'b0);
    req(1'b1, 1'b0, 65, 1'b0);
    req(1'b1, 1'b0, 600, 1'b0);
    req(1'b1, 1'b1, 3725, 1'b0);
    req(1'b0, 1'b0, 5999, 1'b1);
    req(1'b1, 1'b1, 524287, 1'b1);
    reset_mid();
    for (int i = 0; i < 400; i++) begin
      bit sel, m;
      int s;
      sel = 1'($urandom);
      m   = 1'($urandom);
      s   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, sel ? 524287 : 131071))
                                        : int'($urandom_range(0, 8191));
      req(sel, m, s, 1'($urandom_range(0, 7) == 0));
    end
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    reset_state("reset_end");
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
